// File: rtl/gpio_in_pkg.sv
// Shared types and legal parameter ranges for the GPIO input conditioning path.
package gpio_in_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    QUAL_HI = 2'd1,
    ST_HI   = 2'd2,
    QUAL_LO = 2'd3
  } gpio_in_state_t;

  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;
  localparam int unsigned DEBOUNCE_CYCLES_MIN = 1;
  localparam int unsigned DEBOUNCE_CYCLES_MAX = 65535;

endpackage

// File: rtl/gpio_sync_chain.sv
// Reusable metastability synchronizer for a single asynchronous pad level.
module gpio_sync_chain #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Flops kept together and untouched so placement keeps them adjacent.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/gpio_in_conditioner.sv
// Pad input conditioner: synchronizer, consecutive-sample debounce, edge pulses
// and a sticky edge flag.
module gpio_in_conditioner
  import gpio_in_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  input  logic en,
  input  logic sticky_clr,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic edge_sticky
);

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("gpio_in_conditioner: SYNC_STAGES outside 2..4");
  end
  if ((DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) || (DEBOUNCE_CYCLES > DEBOUNCE_CYCLES_MAX)) begin : g_bad_deb
    $error("gpio_in_conditioner: DEBOUNCE_CYCLES outside 1..65535");
  end

  localparam gpio_in_state_t   LP_RST_STATE = RESET_LEVEL ? ST_HI : ST_LO;
  localparam logic [CNT_W-1:0] LP_CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE   = CNT_W'(1);

  logic           w_sync_q;
  gpio_in_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic           r_filt;
  logic           r_filt_q;
  logic           r_rise;
  logic           r_fall;
  logic           r_sticky;

  gpio_sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_in),
    .q   (w_sync_q)
  );

  // Debounce FSM; filt_out is updated on the same edge as the state so it
  // always equals the level implied by the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LP_RST_STATE;
      r_cnt   <= '0;
      r_filt  <= RESET_LEVEL;
    end else begin
      case (r_state)
        ST_LO: begin
          if (en && w_sync_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= ST_HI;
              r_filt  <= 1'b1;
            end else begin
              r_state <= QUAL_HI;
              r_cnt   <= LP_CNT_ONE;
            end
          end
        end
        QUAL_HI: begin
          if (!en || !w_sync_q) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= ST_HI;
            r_cnt   <= '0;
            r_filt  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        ST_HI: begin
          if (en && !w_sync_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= ST_LO;
              r_filt  <= 1'b0;
            end else begin
              r_state <= QUAL_LO;
              r_cnt   <= LP_CNT_ONE;
            end
          end
        end
        QUAL_LO: begin
          if (!en || w_sync_q) begin
            r_state <= ST_HI;
            r_cnt   <= '0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_filt  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        default: begin
          r_state <= LP_RST_STATE;
          r_cnt   <= '0;
          r_filt  <= RESET_LEVEL;
        end
      endcase
    end
  end

  // Edge pulses follow the cycle after filt_out toggles; set beats clear on the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_q <= RESET_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_filt_q <= r_filt;
      r_rise   <= r_filt & ~r_filt_q;
      r_fall   <= ~r_filt & r_filt_q;
      r_sticky <= (r_sticky & ~sticky_clr) | r_rise | r_fall;
    end
  end

  assign filt_out    = r_filt;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign edge_sticky = r_sticky;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for two gpio_in_conditioner configurations sharing stimulus.
module tb_gpio_in_conditioner;

  localparam logic RL = 1'b0;

  logic       clk = 1'b0;
  logic       rst, pad_in, en, sticky_clr;
  logic [1:0] filt, rise, fall, sticky;

  gpio_in_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(RL)) u_dut0 (
    .clk(clk), .rst(rst), .pad_in(pad_in), .en(en), .sticky_clr(sticky_clr),
    .filt_out(filt[0]), .rise_pulse(rise[0]), .fall_pulse(fall[0]), .edge_sticky(sticky[0]));

  gpio_in_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(RL)) u_dut1 (
    .clk(clk), .rst(rst), .pad_in(pad_in), .en(en), .sticky_clr(sticky_clr),
    .filt_out(filt[1]), .rise_pulse(rise[1]), .fall_pulse(fall[1]), .edge_sticky(sticky[1]));

  always #5 clk = ~clk;

  typedef struct { int inst; int cyc; bit is_rise; } ev_t;
  ev_t evq[$];

  int sync_n [2] = '{2, 3};
  int deb_n  [2] = '{16, 1};
  int cyc = 0;
  int n_since_rst = 0;
  bit hist [64];
  bit m_filt [2], m_rise [2], m_fall [2], m_sticky [2], m_pr [2], m_pf [2];
  int m_run [2];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, int i, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc %0d: got %b expected %b", nm, i, cyc, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: each instance sees the pad level from SYNC edges ago; the
  // filtered level flips after DEB consecutive enabled samples that disagree.
  always @(posedge clk) begin
    bit s;
    cyc++;
    if (rst) begin
      n_since_rst = 0;
      evq.delete();
      for (int i = 0; i < 2; i++) begin
        m_filt[i] = RL; m_rise[i] = 0; m_fall[i] = 0; m_sticky[i] = 0;
        m_pr[i] = 0; m_pf[i] = 0; m_run[i] = 0;
      end
    end else begin
      n_since_rst++;
      hist[n_since_rst % 64] = pad_in;
      for (int i = 0; i < 2; i++) begin
        s = (n_since_rst > sync_n[i]) ? hist[(n_since_rst - sync_n[i]) % 64] : RL;
        m_sticky[i] = (sticky_clr ? 1'b0 : m_sticky[i]) | m_rise[i] | m_fall[i];
        m_rise[i] = m_pr[i];
        m_fall[i] = m_pf[i];
        m_pr[i] = 0;
        m_pf[i] = 0;
        if (!en) m_run[i] = 0;
        else if (s != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == deb_n[i]) begin
            m_filt[i] = s;
            m_run[i] = 0;
            m_pr[i] = s;
            m_pf[i] = !s;
            evq.push_back('{inst: i, cyc: cyc + 1, is_rise: s});
          end
        end else m_run[i] = 0;
      end
    end
  end

  function automatic int find_ev(int i);
    for (int k = 0; k < evq.size(); k++) if (evq[k].inst == i) return k;
    return -1;
  endfunction

  // Monitor: samples mid-cycle, pops expected pulse events as they appear.
  always begin
    int k;
    @(posedge clk);
    #4;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_filt", i, filt[i], RL);
        chk("rst_rise", i, rise[i], 1'b0);
        chk("rst_fall", i, fall[i], 1'b0);
        chk("rst_sticky", i, sticky[i], 1'b0);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk("filt", i, filt[i], m_filt[i]);
        chk("sticky", i, sticky[i], m_sticky[i]);
        k = find_ev(i);
        if (rise[i] && fall[i]) chk("both_pulses", i, 1'b1, 1'b0);
        if (rise[i] || fall[i]) begin
          if (k < 0) chk("unexpected_pulse", i, 1'b1, 1'b0);
          else begin
            chk_int($sformatf("pulse_cycle[%0d]", i), cyc, evq[k].cyc);
            chk("pulse_is_rise", i, rise[i], evq[k].is_rise);
            evq.delete(k);
          end
        end else if (k >= 0 && evq[k].cyc <= cyc) begin
          chk_int($sformatf("missed_pulse_cycle[%0d]", i), -1, evq[k].cyc);
          evq.delete(k);
        end
      end
    end
  end

  task automatic drive(bit v, int n);
    pad_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Edges (1-based) until sig[i] reaches val; -1 if the bound expires.
  task automatic edges_until(int i, int which, logic val, int limit, output int c);
    c = -1;
    for (int e = 1; e <= limit; e++) begin
      @(posedge clk);
      #4;
      if ((which == 0 && filt[i] === val) || (which == 1 && rise[i] === val) ||
          (which == 2 && fall[i] === val)) begin
        c = e;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1; pad_in = 1; en = 1; sticky_clr = 0;
    repeat (4) @(negedge clk);
    rst = 0;
    // Rise pulse on edge 2+16+1 after release with pad held high.
    edges_until(0, 1, 1'b1, 40, c);
    chk_int("first_rise_edge", c, 19);
    drive(1, 10);
    drive(0, 40);
    drive(1, 15);
    drive(0, 30);
    chk("glitch_rejected", 0, filt[0], 1'b0);
    drive(1, 16);
    drive(1, 20);
    for (int r = 0; r < 20; r++) begin
      drive(0, 5);
      drive(1, 5);
    end
    chk("toggle_hold", 0, filt[0], 1'b1);
    drive(0, 40);
    // Drop en in mid-qualification, then restart counting from zero.
    pad_in = 1;
    repeat (12) @(negedge clk);
    en = 0;
    repeat (8) @(negedge clk);
    en = 1;
    edges_until(0, 0, 1'b1, 40, c);
    chk_int("en_restart_latency", c, 16);
    drive(1, 10);
    sticky_clr = 1;
    @(negedge clk);
    sticky_clr = 0;
    pad_in = 0;
    edges_until(0, 2, 1'b1, 40, c);
    chk_int("fall_seen", c > 0 ? 1 : 0, 1);
    // edges_until returned at the negedge inside the pulse cycle.
    sticky_clr = 1;
    @(posedge clk);
    #4;
    chk("sticky_set_wins", 0, sticky[0], 1'b1);
    @(negedge clk);
    sticky_clr = 0;
    repeat (3) @(negedge clk);
    sticky_clr = 1;
    @(posedge clk);
    #4;
    chk("sticky_cleared", 0, sticky[0], 1'b0);
    @(negedge clk);
    sticky_clr = 0;
    drive(0, 40);
    pad_in = 1;
    edges_until(1, 0, 1'b1, 20, c);
    chk_int("fast_cfg_latency", c, 4);
    drive(1, 30);
    pad_in = 0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_filt", i, filt[i], RL);
      chk("async_rst_rise", i, rise[i], 1'b0);
      chk("async_rst_fall", i, fall[i], 1'b0);
      chk("async_rst_sticky", i, sticky[i], 1'b0);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    for (int seg = 0; seg < 300; seg++) begin
      pad_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) rst = 1;
      repeat ($urandom_range(1, 24)) begin
        en = ($urandom_range(0, 19) != 0);
        sticky_clr = ($urandom_range(0, 9) == 0);
        @(negedge clk);
        rst = 0;
      end
    end
    en = 1; sticky_clr = 0;
    drive(pad_in, 40);
    chk_int("events_left", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
